vend_ctrl: RTL and testbench

//   Vending-machine transaction controller: accumulates coin credit, dispenses
//   one item once credit reaches PRICE, and returns excess or cancelled credit
//   as a stream of nickel pulses. Sits downstream of the counter/divider stage;

---
 rtl/vend_ctrl.sv | 130 +++++++++++++
 tb/tb_vend_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// vend_ctrl: accumulates coin credit, vends one item at PRICE and pays change out as tick-paced nickels.
// Build option: define VEND_DOLLAR_EN to credit coin_type 2'b11 as a 100c coin (rejected otherwise).
module vend_ctrl #(
    parameter int PRICE    = 65,
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic                change_nickel,
    output logic                coin_reject,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(5);

    state_t              state;
    logic                coin_ok;
    logic [CREDIT_W-1:0] coin_value;
    logic [CREDIT_W-1:0] credit_sum;

    always_comb begin
        coin_ok    = 1'b1;
        coin_value = '0;
        case (coin_type)
            2'b00:   coin_value = CREDIT_W'(5);
            2'b01:   coin_value = CREDIT_W'(10);
            2'b10:   coin_value = CREDIT_W'(25);
            default: begin
`ifdef VEND_DOLLAR_EN
                coin_value = CREDIT_W'(100);
`else
                coin_ok    = 1'b0;
`endif
            end
        endcase
    end

    // Cannot wrap: a coin only lands while credit < PRICE, so the sum stays below 2^CREDIT_W.
    assign credit_sum = credit + coin_value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            credit        <= '0;
            dispense      <= 1'b0;
            change_nickel <= 1'b0;
            coin_reject   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            dispense      <= 1'b0;
            change_nickel <= 1'b0;
            coin_reject   <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    // A coin racing a cancel loses; cancel itself only matters once credit exists.
                    if (coin_valid && (cancel || !coin_ok))
                        coin_reject <= 1'b1;
                    if (cancel && state == COLLECT) begin
                        state <= CHANGE;
                        busy  <= 1'b1;
                    end else if (coin_valid && !cancel && coin_ok) begin
                        credit <= credit_sum;
                        if (credit_sum >= PRICE_C) begin
                            state <= VEND;
                            busy  <= 1'b1;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                VEND: begin
                    coin_reject <= coin_valid;
                    dispense    <= 1'b1;
                    credit      <= credit - PRICE_C;
                    if (credit == PRICE_C) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= CHANGE;
                        busy  <= 1'b1;
                    end
                end
                CHANGE: begin
                    coin_reject <= coin_valid;
                    if (tick) begin
                        change_nickel <= 1'b1;
                        credit        <= credit - NICKEL_C;
                        if (credit == NICKEL_C) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Structural invariants of the credit/state relationship.
    a_idle_zero: assert property (@(posedge clk) disable iff (reset)
        (state == IDLE) |-> (credit == '0));
    a_collect_range: assert property (@(posedge clk) disable iff (reset)
        (state == COLLECT) |-> (credit != '0 && credit < PRICE_C));
    a_vend_enough: assert property (@(posedge clk) disable iff (reset)
        (state == VEND) |-> (credit >= PRICE_C));
    a_change_nonzero: assert property (@(posedge clk) disable iff (reset)
        (state == CHANGE) |-> (credit != '0));
    a_busy_track: assert property (@(posedge clk) disable iff (reset)
        busy == (state == VEND || state == CHANGE));
    a_nickel_multiple: assert property (@(posedge clk) disable iff (reset)
        (credit % NICKEL_C) == '0);

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed scenarios for vend_ctrl against a transaction-level credit model.
// Honours VEND_DOLLAR_EN the same way the design does.
module tb_vend_ctrl;

    localparam int PRICE    = 65;
    localparam int CREDIT_W = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                tick;
    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic                change_nickel;
    logic                coin_reject;
    logic                busy;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int disp_cnt = 0;
    int nick_cnt = 0;
    int busy_cnt = 0;
    bit chk_en   = 1'b0;

    // Model: credit in cents, an item owed, and a refund in progress.
    int m_credit = 0;
    bit m_vend   = 1'b0;
    bit m_refund = 1'b0;
    bit e_disp   = 1'b0;
    bit e_nick   = 1'b0;
    bit e_rej    = 1'b0;

    vend_ctrl #(.PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .tick          (tick),
        .coin_valid    (coin_valid),
        .coin_type     (coin_type),
        .cancel        (cancel),
        .credit        (credit),
        .dispense      (dispense),
        .change_nickel (change_nickel),
        .coin_reject   (coin_reject),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic int coin_cents(input logic [1:0] t);
        int cents;
        case (t)
            2'b00:   cents = 5;
            2'b01:   cents = 10;
            2'b10:   cents = 25;
            default: begin
`ifdef VEND_DOLLAR_EN
                cents = 100;
`else
                cents = 0;
`endif
            end
        endcase
        return cents;
    endfunction

    always @(posedge clk or posedge reset) begin
        int v;
        if (reset) begin
            m_credit = 0;
            m_vend   = 1'b0;
            m_refund = 1'b0;
            e_disp   = 1'b0;
            e_nick   = 1'b0;
            e_rej    = 1'b0;
        end else begin
            e_disp = 1'b0;
            e_nick = 1'b0;
            e_rej  = 1'b0;
            if (m_vend) begin
                e_disp   = 1'b1;
                m_credit = m_credit - PRICE;
                m_vend   = 1'b0;
                m_refund = (m_credit > 0);
                e_rej    = (coin_valid === 1'b1);
            end else if (m_refund) begin
                e_rej = (coin_valid === 1'b1);
                if (tick === 1'b1) begin
                    e_nick   = 1'b1;
                    m_credit = m_credit - 5;
                    if (m_credit == 0) m_refund = 1'b0;
                end
            end else begin
                v = coin_cents(coin_type);
                if (cancel === 1'b1 && m_credit > 0) begin
                    m_refund = 1'b1;
                    e_rej    = (coin_valid === 1'b1);
                end else if (coin_valid === 1'b1) begin
                    if (cancel === 1'b1 || v == 0) begin
                        e_rej = 1'b1;
                    end else begin
                        m_credit = m_credit + v;
                        m_vend   = (m_credit >= PRICE);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc credit",        32'(credit),        32'(m_credit));
            check("cyc busy",          32'(busy),          32'(m_vend || m_refund));
            check("cyc dispense",      32'(dispense),      32'(e_disp));
            check("cyc change_nickel", 32'(change_nickel), 32'(e_nick));
            check("cyc coin_reject",   32'(coin_reject),   32'(e_rej));
        end
        if (dispense === 1'b1)      disp_cnt++;
        if (change_nickel === 1'b1) nick_cnt++;
        if (busy === 1'b1)          busy_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick = (cyc % 4 == 0);
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        step();
        coin_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        check({name, " idle within budget"}, 32'(busy), 32'd0);
        // Let the monitor count the final edge's pulses.
        step();
        step();
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int d0, n0, b0, c, k, got;
        reset      = 1'b1;
        tick       = 1'b0;
        coin_valid = 1'b0;
        coin_type  = 2'b00;
        cancel     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset credit",   32'(credit),        32'd0);
        check("reset dispense", 32'(dispense),      32'd0);
        check("reset nickel",   32'(change_nickel), 32'd0);
        check("reset reject",   32'(coin_reject),   32'd0);
        check("reset busy",     32'(busy),          32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;
        step();

        // 1: exact price, no change
        d0 = disp_cnt; n0 = nick_cnt; b0 = busy_cnt;
        coin(2'b10); check("s1 credit 25", 32'(credit), 32'd25);
        coin(2'b10); check("s1 credit 50", 32'(credit), 32'd50);
        coin(2'b01); check("s1 credit 60", 32'(credit), 32'd60);
        coin(2'b00); check("s1 credit 65", 32'(credit), 32'd65);
        check("s1 busy in vend", 32'(busy), 32'd1);
        step();
        check("s1 dispense", 32'(dispense), 32'd1);
        check("s1 credit 0", 32'(credit),   32'd0);
        check("s1 busy low", 32'(busy),     32'd0);
        repeat (8) step();
        check("s1 dispense count", 32'(disp_cnt - d0), 32'd1);
        check("s1 nickel count",   32'(nick_cnt - n0), 32'd0);
        check("s1 busy cycles",    32'(busy_cnt - b0), 32'd1);

        // 2: overpay by 10c, two nickels back
        d0 = disp_cnt; n0 = nick_cnt;
        coin(2'b10); coin(2'b10); coin(2'b10);
        check("s2 credit 75", 32'(credit), 32'd75);
        step();
        check("s2 dispense",  32'(dispense), 32'd1);
        check("s2 credit 10", 32'(credit),   32'd10);
        wait_idle(40, "s2");
        check("s2 dispense count", 32'(disp_cnt - d0), 32'd1);
        check("s2 nickel count",   32'(nick_cnt - n0), 32'd2);
        check("s2 credit 0",       32'(credit),        32'd0);

        // 3: cancel refunds everything
        d0 = disp_cnt; n0 = nick_cnt;
        coin(2'b01); coin(2'b10);
        check("s3 credit 35", 32'(credit), 32'd35);
        do_cancel();
        check("s3 busy", 32'(busy), 32'd1);
        check("s3 credit held", 32'(credit), 32'd35);
        wait_idle(60, "s3");
        check("s3 dispense count", 32'(disp_cnt - d0), 32'd0);
        check("s3 nickel count",   32'(nick_cnt - n0), 32'd7);
        check("s3 credit 0",       32'(credit),        32'd0);

        // 4a: coin during change is rejected
        n0 = nick_cnt;
        coin(2'b10); coin(2'b10); coin(2'b10);
        step();
        if (tick === 1'b1) step();
        c = int'(credit);
        coin(2'b00);
        check("s4a reject", 32'(coin_reject), 32'd1);
        check("s4a credit", 32'(credit),      32'(c));
        check("s4a busy",   32'(busy),        32'd1);
        wait_idle(40, "s4a");
        check("s4a nickel count", 32'(nick_cnt - n0), 32'd2);

        // 4b: cancel and coin together in COLLECT
        n0 = nick_cnt;
        coin(2'b01);
        cancel = 1'b1; coin_valid = 1'b1; coin_type = 2'b10;
        step();
        cancel = 1'b0; coin_valid = 1'b0;
        check("s4b reject", 32'(coin_reject), 32'd1);
        check("s4b credit", 32'(credit),      32'd10);
        check("s4b busy",   32'(busy),        32'd1);
        wait_idle(40, "s4b");
        check("s4b nickel count", 32'(nick_cnt - n0), 32'd2);

        // 5: dollar coin
        d0 = disp_cnt; n0 = nick_cnt;
        coin(2'b11);
`ifdef VEND_DOLLAR_EN
        check("s5 credit 100", 32'(credit), 32'd100);
        step();
        check("s5 dispense",  32'(dispense), 32'd1);
        check("s5 credit 35", 32'(credit),   32'd35);
        wait_idle(60, "s5");
        check("s5 dispense count", 32'(disp_cnt - d0), 32'd1);
        check("s5 nickel count",   32'(nick_cnt - n0), 32'd7);
`else
        check("s5 reject",   32'(coin_reject), 32'd1);
        check("s5 credit 0", 32'(credit),      32'd0);
        check("s5 busy",     32'(busy),        32'd0);
        step();
        check("s5 reject one clk", 32'(coin_reject), 32'd0);
`endif

        // 6: reset mid-refund
        coin(2'b01); coin(2'b10);
        do_cancel();
        got = 0; k = 0;
        while (got < 2 && k < 40) begin
            step();
            k++;
            if (change_nickel === 1'b1) got++;
        end
        check("s6 two nickels before reset", 32'(got), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("s6 reset credit", 32'(credit),        32'd0);
        check("s6 reset nickel", 32'(change_nickel), 32'd0);
        check("s6 reset busy",   32'(busy),          32'd0);
        check("s6 reset disp",   32'(dispense),      32'd0);
        check("s6 reset reject", 32'(coin_reject),   32'd0);
        step();
        step();
        reset = 1'b0;
        d0 = disp_cnt; n0 = nick_cnt;
        repeat (20) step();
        check("s6 no nickels after", 32'(nick_cnt - n0), 32'd0);
        check("s6 no dispense after", 32'(disp_cnt - d0), 32'd0);
        check("s6 idle credit", 32'(credit), 32'd0);
        coin(2'b00);
        check("s6 recovers", 32'(credit), 32'd5);
        do_cancel();
        wait_idle(40, "s6 tail");

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
